pong_game: RTL

POÑG_GAME -- requirements
Module: pong_game

---
 rtl/pong_game.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/pong_game.sv
// Two-player pong game engine: serve timing, paddle/ball motion, collisions and scoring.
module pong_game #(
   parameter int unsigned CORDW        = 10,
   parameter int unsigned H_RES        = 640,
   parameter int unsigned V_RES        = 480,
   parameter int unsigned BALL_SIZE    = 8,
   parameter int unsigned BALL_SPD     = 2,
   parameter int unsigned PAD_W        = 8,
   parameter int unsigned PAD_H        = 64,
   parameter int unsigned PAD_OFS      = 16,
   parameter int unsigned PAD_SPD      = 4,
   parameter int unsigned SCORE_W      = 4,
   parameter int unsigned WIN_SCORE    = 9,
   parameter int unsigned SERVE_FRAMES = 60
) (
   input  logic               pix_clk,
   input  logic               rst_pix_n,
   input  logic               frame,
   input  logic               start,
   input  logic [1:0]         btn_up,
   input  logic [1:0]         btn_dn,
   output logic [CORDW-1:0]   ball_x,
   output logic [CORDW-1:0]   ball_y,
   output logic [CORDW-1:0]   pad_y0,
   output logic [CORDW-1:0]   pad_y1,
   output logic [SCORE_W-1:0] score0,
   output logic [SCORE_W-1:0] score1,
   output logic               playing,
   output logic               game_over,
   output logic [1:0]         point,
   output logic               upd_done
);

   // One extra bit of headroom so sums are compared before truncation.
   localparam int unsigned AW    = CORDW + 1;
   localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

   localparam logic [CORDW-1:0] BALL_X0 = CORDW'((H_RES - BALL_SIZE) / 2);
   localparam logic [CORDW-1:0] BALL_Y0 = CORDW'((V_RES - BALL_SIZE) / 2);
   localparam logic [CORDW-1:0] PAD_Y0  = CORDW'((V_RES - PAD_H) / 2);

   localparam logic [AW-1:0] SPD     = AW'(BALL_SPD);
   localparam logic [AW-1:0] BS      = AW'(BALL_SIZE);
   localparam logic [AW-1:0] PH      = AW'(PAD_H);
   localparam logic [AW-1:0] PSPD    = AW'(PAD_SPD);
   localparam logic [AW-1:0] Y_MAX   = AW'(V_RES - BALL_SIZE);
   localparam logic [AW-1:0] X_MAX   = AW'(H_RES - BALL_SIZE);
   localparam logic [AW-1:0] PAD_MAX = AW'(V_RES - PAD_H);
   localparam logic [AW-1:0] EDGE_L  = AW'(PAD_OFS + PAD_W);
   localparam logic [AW-1:0] EDGE_R  = AW'(H_RES - PAD_OFS - PAD_W - BALL_SIZE);

   typedef enum logic [2:0] {
      IDLE,
      SERVE_WAIT,
      PLAY,
      UPD_PAD,
      UPD_BALL,
      OVER
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   serve_cnt;
   logic               dx_rt;
   logic               dy_dn;

   logic [AW-1:0]      bx, by, p0, p1;
   logic [CORDW-1:0]   nx, ny;
   logic               ndx, ndy;
   logic               ovl0, ovl1;
   logic               miss_l, miss_r;
   logic [SCORE_W-1:0] score_new;

   // Saturating paddle step; both or neither button holds the paddle.
   function automatic logic [CORDW-1:0] pad_move(input logic [CORDW-1:0] p,
                                                  input logic up, input logic dn);
      logic [AW-1:0] pw;
      pw = AW'(p);
      if (up && !dn) begin
         return (pw < PSPD) ? '0 : CORDW'(pw - PSPD);
      end else if (dn && !up) begin
         return (pw + PSPD > PAD_MAX) ? CORDW'(PAD_MAX) : CORDW'(pw + PSPD);
      end
      return p;
   endfunction

   // Next ball position, wall bounces, paddle hits and misses from the current registers.
   always_comb begin
      bx     = AW'(ball_x);
      by     = AW'(ball_y);
      p0     = AW'(pad_y0);
      p1     = AW'(pad_y1);
      ny     = ball_y;
      ndy    = dy_dn;
      nx     = ball_x;
      ndx    = dx_rt;
      miss_l = 1'b0;
      miss_r = 1'b0;

      if (dy_dn) begin
         if (by + SPD > Y_MAX) begin
            ny  = CORDW'(Y_MAX);
            ndy = 1'b0;
         end else begin
            ny  = CORDW'(by + SPD);
         end
      end else begin
         if (by < SPD) begin
            ny  = '0;
            ndy = 1'b1;
         end else begin
            ny  = CORDW'(by - SPD);
         end
      end

      ovl0 = (by + BS > p0) && (by < p0 + PH);
      ovl1 = (by + BS > p1) && (by < p1 + PH);

      if (dx_rt) begin
         if ((bx <= EDGE_R) && (bx + SPD >= EDGE_R) && ovl1) begin
            nx  = CORDW'(EDGE_R);
            ndx = 1'b0;
         end else if (bx + SPD > X_MAX) begin
            miss_r = 1'b1;
         end else begin
            nx = CORDW'(bx + SPD);
         end
      end else begin
         if ((bx >= EDGE_L) && (bx - SPD <= EDGE_L) && ovl0) begin
            nx  = CORDW'(EDGE_L);
            ndx = 1'b1;
         end else if (bx < SPD) begin
            miss_l = 1'b1;
         end else begin
            nx = CORDW'(bx - SPD);
         end
      end

      score_new = miss_l ? (score1 + SCORE_W'(1)) : (score0 + SCORE_W'(1));
   end

   // Game FSM with all game state and status outputs registered.
   always_ff @(posedge pix_clk or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         state     <= IDLE;
         serve_cnt <= '0;
         ball_x    <= BALL_X0;
         ball_y    <= BALL_Y0;
         pad_y0    <= PAD_Y0;
         pad_y1    <= PAD_Y0;
         dx_rt     <= 1'b1;
         dy_dn     <= 1'b1;
         score0    <= '0;
         score1    <= '0;
         playing   <= 1'b0;
         game_over <= 1'b0;
         point     <= '0;
         upd_done  <= 1'b0;
      end else begin
         point    <= '0;
         upd_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= SERVE_WAIT;
                  serve_cnt <= '0;
               end
            end
            SERVE_WAIT: begin
               if (frame) begin
                  serve_cnt <= serve_cnt + CNT_W'(1);
                  if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                     state   <= PLAY;
                     playing <= 1'b1;
                  end
               end
            end
            PLAY: begin
               if (frame) begin
                  state <= UPD_PAD;
               end
            end
            UPD_PAD: begin
               pad_y0 <= pad_move(pad_y0, btn_up[0], btn_dn[0]);
               pad_y1 <= pad_move(pad_y1, btn_up[1], btn_dn[1]);
               state  <= UPD_BALL;
            end
            UPD_BALL: begin
               upd_done <= 1'b1;
               if (miss_l || miss_r) begin
                  // Re-centre and serve toward the player who conceded.
                  point  <= {miss_l, miss_r};
                  ball_x <= BALL_X0;
                  ball_y <= BALL_Y0;
                  dx_rt  <= miss_r;
                  if (miss_l) begin
                     score1 <= score_new;
                  end else begin
                     score0 <= score_new;
                  end
                  playing <= 1'b0;
                  if (score_new == SCORE_W'(WIN_SCORE)) begin
                     state     <= OVER;
                     game_over <= 1'b1;
                  end else begin
                     state     <= SERVE_WAIT;
                     serve_cnt <= '0;
                  end
               end else begin
                  ball_x <= nx;
                  ball_y <= ny;
                  dx_rt  <= ndx;
                  dy_dn  <= ndy;
                  state  <= PLAY;
               end
            end
            OVER: begin
               if (start) begin
                  score0    <= '0;
                  score1    <= '0;
                  ball_x    <= BALL_X0;
                  ball_y    <= BALL_Y0;
                  pad_y0    <= PAD_Y0;
                  pad_y1    <= PAD_Y0;
                  game_over <= 1'b0;
                  serve_cnt <= '0;
                  state     <= SERVE_WAIT;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
